// File: rtl/hack_pkg.sv
// Shared widths and FSM state encoding for the 16-bit shift-add multiplier.
package hack_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ITER_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_16_if.sv
// Request/result bundle between a multiplier client (master) and mul_16 (slave).
interface mul_16_if;
    import hack_pkg::*;

    logic              start;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              ready;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] out;

    modport master (
        output start, a, b,
        input  ready, busy, done, out
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, out
    );

endinterface

// File: rtl/mul_16_add.sv
// 16-bit adder used for the accumulate step; carry-out is dropped (mod 2^16).
module add_16
    import hack_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_cin,
    output logic [WORD_W-1:0] o_sum
);

    assign o_sum = i_a + i_b + WORD_W'(i_cin);

endmodule

// File: rtl/mul_16.sv
// Sequential shift-add multiplier: one multiplier bit per RUN cycle, product mod 2^16.
module mul_16
    import hack_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic    clk,
    input  logic    reset,
    mul_16_if.slave bus
);

    mul_state_t        r_state;
    mul_state_t        w_next_state;
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b;
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] r_out;
    logic [ITER_W-1:0] r_iter;
    logic [WORD_W-1:0] w_pp;
    logic [WORD_W-1:0] w_sum;
    logic              w_last;

    assign w_pp = r_b[0] ? r_a : '0;

    add_16 u_add (
        .i_a   (r_acc),
        .i_b   (w_pp),
        .i_cin (1'b0),
        .o_sum (w_sum)
    );

    // Final iteration: counter wrap, or no multiplier bits left when exiting early.
    assign w_last = (r_iter == ITER_W'(WORD_W - 1)) ||
                    (EARLY_EXIT && ((r_b >> 1) == '0));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_iter  <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a    <= bus.a;
                        r_b    <= bus.b;
                        r_acc  <= '0;
                        r_iter <= '0;
                    end
                end
                RUN: begin
                    r_acc  <= w_sum;
                    r_a    <= r_a << 1;
                    r_b    <= r_b >> 1;
                    r_iter <= r_iter + ITER_W'(1);
                    if (w_last) r_out <= w_sum;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = (r_state == IDLE);
    assign bus.busy  = (r_state == RUN);
    assign bus.done  = (r_state == DONE);
    assign bus.out   = r_out;

endmodule

// File: tb/tb_mul_16.sv
// Bench for mul_16: both EARLY_EXIT variants against a latency/product reference model.
module tb_mul_16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start_v [2];
    logic [15:0] a_v     [2];
    logic [15:0] b_v     [2];
    logic        ready_w [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [15:0] out_w   [2];

    mul_16_if if0 ();
    mul_16_if if1 ();

    assign if0.start = start_v[0];
    assign if0.a     = a_v[0];
    assign if0.b     = b_v[0];
    assign if1.start = start_v[1];
    assign if1.a     = a_v[1];
    assign if1.b     = b_v[1];
    assign ready_w[0] = if0.ready;
    assign busy_w[0]  = if0.busy;
    assign done_w[0]  = if0.done;
    assign out_w[0]   = if0.out;
    assign ready_w[1] = if1.ready;
    assign busy_w[1]  = if1.busy;
    assign done_w[1]  = if1.done;
    assign out_w[1]   = if1.out;

    mul_16 #(.EARLY_EXIT(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    mul_16 #(.EARLY_EXIT(1'b1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected number of RUN edges for an operation on instance d.
    function automatic int exp_lat(input int d, input logic [15:0] y);
        if (d == 0) return 16;
        for (int i = 15; i >= 0; i--) if (y[i]) return i + 1;
        return 1;
    endfunction

    // Reference model: remaining cycles until done, pending product, visible result.
    int          m_rem  [2] = '{0, 0};
    bit          m_done [2] = '{1'b0, 1'b0};
    logic [15:0] m_pend [2] = '{16'h0, 16'h0};
    logic [15:0] m_out  [2] = '{16'h0, 16'h0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_rem[d]  <= 0;
                m_done[d] <= 1'b0;
                m_out[d]  <= 16'h0;
            end else if (m_done[d]) begin
                m_done[d] <= 1'b0;
            end else if (m_rem[d] > 0) begin
                m_rem[d] <= m_rem[d] - 1;
                if (m_rem[d] == 1) begin
                    m_done[d] <= 1'b1;
                    m_out[d]  <= m_pend[d];
                end
            end else if (start_v[d]) begin
                m_pend[d] <= 16'((32'(a_v[d]) * 32'(b_v[d])) & 32'hFFFF);
                m_rem[d]  <= exp_lat(d, b_v[d]);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("ready[%0d]", d), 32'(ready_w[d]), 32'(m_rem[d] == 0 && !m_done[d]));
                chk($sformatf("busy[%0d]", d),  32'(busy_w[d]),  32'(m_rem[d] > 0));
                chk($sformatf("done[%0d]", d),  32'(done_w[d]),  32'(m_done[d]));
                chk($sformatf("out[%0d]", d),   32'(out_w[d]),   32'(m_out[d]));
            end
        end
    end

    task automatic run_op(input int d, input logic [15:0] x, input logic [15:0] y,
                          output logic [15:0] res, output int lat, output int bcnt);
        @(negedge clk);
        start_v[d] = 1'b1;
        a_v[d]     = x;
        b_v[d]     = y;
        @(negedge clk);
        start_v[d] = 1'b0;
        a_v[d]     = 16'($urandom);
        b_v[d]     = 16'($urandom);
        lat  = 0;
        bcnt = busy_w[d] ? 1 : 0;
        while (!done_w[d] && lat < 60) begin
            @(negedge clk);
            lat++;
            if (busy_w[d]) bcnt++;
        end
        res = out_w[d];
    endtask

    logic [15:0] res;
    logic [15:0] prev;
    logic [15:0] x, y;
    int          lat, bcnt, ndone, d;

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = 16'h0;
            b_v[i]     = 16'h0;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        chk("rst_ready0", 32'(ready_w[0]), 32'd1);
        chk("rst_busy1",  32'(busy_w[1]),  32'd0);
        chk("rst_done0",  32'(done_w[0]),  32'd0);
        chk("rst_out1",   32'(out_w[1]),   32'd0);

        run_op(0, 16'd3, 16'd5, res, lat, bcnt);
        chk("3x5_out", 32'(res), 32'd15);
        chk("3x5_lat", 32'(lat), 32'd16);
        chk("3x5_busy", 32'(bcnt), 32'd16);

        // Back-to-back: accept in the first IDLE cycle, previous out held until new done.
        prev = res;
        @(negedge clk);
        chk("b2b_ready", 32'(ready_w[0]), 32'd1);
        start_v[0] = 1'b1; a_v[0] = 16'hFFFF; b_v[0] = 16'hFFFF;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("b2b_busy", 32'(busy_w[0]), 32'd1);
        chk("b2b_hold", 32'(out_w[0]), 32'(prev));
        lat = 0;
        while (!done_w[0] && lat < 60) begin
            @(negedge clk);
            lat++;
            if (!done_w[0]) chk("b2b_hold_run", 32'(out_w[0]), 32'(prev));
        end
        chk("ffff_out", 32'(out_w[0]), 32'h0001);
        chk("ffff_lat", 32'(lat), 32'd16);

        run_op(0, 16'h0100, 16'h0100, res, lat, bcnt);
        chk("0100_out", 32'(res), 32'h0000);
        run_op(0, 16'h00FF, 16'h0101, res, lat, bcnt);
        chk("00ff_out", 32'(res), 32'hFFFF);

        run_op(1, 16'h1234, 16'h0000, res, lat, bcnt);
        chk("ee_zero_out", 32'(res), 32'd0);
        chk("ee_zero_lat", 32'(lat), 32'd1);
        run_op(1, 16'd7, 16'd5, res, lat, bcnt);
        chk("ee_7x5_out", 32'(res), 32'd35);
        chk("ee_7x5_lat", 32'(lat), 32'd3);

        // Start held high with changing operands during RUN must not queue.
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 16'd2; b_v[0] = 16'd3;
        @(negedge clk);
        a_v[0] = 16'd9; b_v[0] = 16'd9;
        ndone = 0; lat = 0;
        while (!done_w[0] && lat < 60) begin
            @(negedge clk);
            lat++;
            a_v[0] = 16'($urandom); b_v[0] = 16'($urandom);
        end
        start_v[0] = 1'b0;
        chk("nq_out", 32'(out_w[0]), 32'd6);
        repeat (20) begin
            @(negedge clk);
            if (done_w[0]) ndone++;
        end
        chk("nq_extra_done", 32'(ndone), 32'd0);
        chk("nq_ready", 32'(ready_w[0]), 32'd1);

        // Reset in the middle of a run abandons it and clears out.
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 16'd10; b_v[0] = 16'd10;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_out", 32'(out_w[0]), 32'd0);
        chk("mr_ready", 32'(ready_w[0]), 32'd1);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_w[0]) ndone++;
        end
        chk("mr_no_done", 32'(ndone), 32'd0);
        run_op(0, 16'd4, 16'd4, res, lat, bcnt);
        chk("mr_4x4_out", 32'(res), 32'd16);

        for (int i = 0; i < 24; i++) begin
            d = i % 2;
            x = 16'($urandom);
            y = 16'($urandom);
            if (d == 1) y = y >> $urandom_range(0, 15);
            run_op(d, x, y, res, lat, bcnt);
            chk($sformatf("rnd%0d_out", i), 32'(res), 32'((32'(x) * 32'(y)) & 32'hFFFF));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat(d, y)));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mul_16.md
MUL_16 -- requirements
Module: mul_16

Interface
REQ-001 Parameter: EARLY_EXIT, default 0; 1 = terminate RUN once the remaining multiplier bits are all zero.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; accepted only when ready=1.
REQ-005 a  input  16  multiplicand; sampled on the accepting edge only.
REQ-006 b  input  16  multiplier; sampled on the accepting edge only.
REQ-007 ready  output  1  high in IDLE; block can accept start.
REQ-008 busy  output  1  high in RUN.
REQ-009 done  output  1  one-cycle pulse; out is valid this cycle.
REQ-010 out  output  16  product a*b mod 2^16; registered.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE; ready, busy and done SHALL decode directly from the state.
REQ-012 IDLE with start=1 SHALL move to RUN and load a_reg=a, b_reg=b, acc=0, iter=0 on the same edge.
REQ-013 IDLE with start=0 SHALL stay in IDLE with all registers held.
REQ-014 Each RUN edge SHALL perform one iteration.
  - acc <= acc + (b_reg[0] ? a_reg : 0), using the add_16 sub-module.
  - a_reg <= a_reg << 1, zero-filled.
  - b_reg <= b_reg >> 1, zero-filled.
  - iter <= iter + 1.
REQ-015 Arithmetic SHALL be 16-bit modulo 2^16; carries out of bit 15 and bits shifted out of a_reg SHALL be discarded.
REQ-016 RUN SHALL go to DONE on the edge completing iteration 16 (iter==15), or, when EARLY_EXIT=1, on the first edge where (b_reg >> 1)==0.
REQ-017 On the RUN-to-DONE edge, out SHALL load the final accumulated value.
REQ-018 DONE SHALL last exactly one cycle with done=1 and SHALL return to IDLE unconditionally.
REQ-019 start SHALL be ignored in RUN and DONE; it is neither queued nor allowed to corrupt the operation in flight.
REQ-020 Latency: with start accepted at edge E0, done SHALL be high in the cycle after edge Ek.
  - k=16 when EARLY_EXIT=0.
  - k=max(1, index of the MSB set in b + 1) when EARLY_EXIT=1.
REQ-021 out SHALL hold its value from DONE until the next RUN-to-DONE edge, including through IDLE and the next RUN.
REQ-022 a and b changing after the accepting edge SHALL have no effect on the result.

Reset
REQ-023 reset=1 SHALL force, on the next edge: state=IDLE, out=0, acc=0, a_reg=0, b_reg=0, iter=0, so ready=1, busy=0, done=0.
REQ-024 reset SHALL take priority over start and over every state transition.
REQ-025 Reset during RUN or DONE SHALL abandon the operation with no done pulse and SHALL clear out.

Structure
REQ-026 A shared package hack_pkg SHALL hold WORD_W=16 and the mul_state_t enum (IDLE, RUN, DONE); the iteration counter width ($clog2(WORD_W)) SHALL derive from WORD_W.
REQ-027 Exactly one sub-module SHALL be used: add_16, computing acc + partial product with carry-in 0.
REQ-028 The shifters, partial-product mux, counter and FSM SHALL be local logic.

Verification
REQ-029 EARLY_EXIT=0, start with a=3, b=5 -> done high exactly 16 cycles after the accepting edge, out=15, busy high for 16 cycles.
REQ-030 a=0xFFFF, b=0xFFFF -> out=0x0001; a=0x0100, b=0x0100 -> out=0x0000; a=0x00FF, b=0x0101 -> out=0xFFFF.
REQ-031 EARLY_EXIT=1: a=0x1234, b=0 -> done after 1 iteration, out=0; a=7, b=5 -> done after 3 iterations, out=35.
REQ-032 start with a=2, b=3; re-assert start with a=9, b=9 and change a/b during RUN -> single done, out=6, second start not queued.
REQ-033 Assert reset at iteration 8 of a=10, b=10 -> no done, out=0, ready=1; a new start with a=4, b=4 then gives out=16.
REQ-034 Back-to-back: start in the first IDLE cycle after DONE -> accepted; the previous out is held until the new DONE.
